dcp_master: RTL and testbench

Debug-control-port master that drives the CPU's debug side: `inst_we`/`inst_addr`/`inst_in`, `data_we`/`data_addr`/`data_in`, `rf_dcp_rd`/`rf_addr`, and reads back `inst_out`/`data_out`/`rf_out`. A host issues single commands over a valid/ready channel; the block sequences the memory/register-file strobes and gates the CPU clock enable for run/step/halt. Each command returns exactly one response. The block sits between the host link (UART/switch front end) and the `CPU` top.

---
 rtl/dcp_master_if.sv | 23 ++
 rtl/dcp_master.sv | 176 +++++++++++++++++
 tb/tb_dcp_master.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/dcp_master_if.sv
// Host command/response channel of the debug-control-port master.
// The master modport is the host side; the slave modport is dcp_master.
interface dcp_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/dcp_master.sv
// Debug-control-port master: sequences CPU debug strobes and gates the CPU clock enable.
// Optional PC breakpoint (SETBP/CLRBP) is built when DCP_BREAKPOINT_EN is defined.
module dcp_master (
    input  logic         clk,
    input  logic         rstn,
    dcp_master_if.slave  bus,
    output logic         inst_we,
    output logic [7:0]   inst_addr,
    output logic [31:0]  inst_in,
    input  logic [31:0]  inst_out,
    output logic         data_we,
    output logic [7:0]   data_addr,
    output logic [31:0]  data_in,
    input  logic [31:0]  data_out,
    output logic         rf_dcp_rd,
    output logic         rf_dcp_we,
    output logic [4:0]   rf_addr,
    input  logic [31:0]  rf_out,
    input  logic [31:0]  pc,
    input  logic         stop,
    output logic         cpu_ce,
    output logic         running,
    output logic [1:0]   halt_cause
);
    localparam logic [3:0] OP_WINST = 4'd0, OP_RINST = 4'd1, OP_WDATA = 4'd2,
                           OP_RDATA = 4'd3, OP_RRF   = 4'd4, OP_RUN   = 4'd5,
                           OP_STEP  = 4'd6, OP_HALT  = 4'd7, OP_SETBP = 4'd8,
                           OP_CLRBP = 4'd9;
`ifdef DCP_BREAKPOINT_EN
    localparam logic BP_EN = 1'b1;
`else
    localparam logic BP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state;
    logic [3:0]  op_q;
    logic        err_q;
    logic        step_pulse;
    logic        pc_pend;
    logic [31:0] rsp_q;
    logic        legal;
    logic        bp_hit;

`ifdef DCP_BREAKPOINT_EN
    logic [31:0] bp_pc;
    logic        bp_valid;
    logic        first_run_cycle;
    // The first cycle after RUN is masked so a resume from the breakpoint PC moves on.
    assign bp_hit = running & bp_valid & (pc == bp_pc) & ~first_run_cycle;
`else
    assign bp_hit = 1'b0;
`endif

    assign rf_dcp_we     = 1'b0;
    assign bus.cmd_ready = (state == IDLE);
    // STEP reports the PC the CPU holds after the stepped edge, visible from RESP entry.
    assign bus.rsp_data  = pc_pend ? pc : rsp_q;
    assign cpu_ce        = (running & ~stop & ~bp_hit) | step_pulse;

    always_comb begin
        legal = 1'b0;
        case (bus.cmd_op)
            OP_WINST, OP_RINST, OP_WDATA,
            OP_RDATA, OP_RRF, OP_STEP:   legal = ~running;
            OP_RUN, OP_HALT:             legal = 1'b1;
            OP_SETBP, OP_CLRBP:          legal = BP_EN;
            default:                     legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            op_q          <= 4'd0;
            err_q         <= 1'b0;
            inst_we       <= 1'b0;
            data_we       <= 1'b0;
            rf_dcp_rd     <= 1'b0;
            step_pulse    <= 1'b0;
            inst_addr     <= 8'd0;
            data_addr     <= 8'd0;
            rf_addr       <= 5'd0;
            inst_in       <= 32'd0;
            data_in       <= 32'd0;
            rsp_q         <= 32'd0;
            pc_pend       <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            running       <= 1'b0;
            halt_cause    <= 2'd0;
`ifdef DCP_BREAKPOINT_EN
            bp_pc           <= 32'd0;
            bp_valid        <= 1'b0;
            first_run_cycle <= 1'b0;
`endif
        end else begin
            // Strobes are registered at accept so they cover exactly the ACCESS cycle.
            inst_we    <= 1'b0;
            data_we    <= 1'b0;
            rf_dcp_rd  <= 1'b0;
            step_pulse <= 1'b0;
`ifdef DCP_BREAKPOINT_EN
            first_run_cycle <= 1'b0;
`endif
            case (state)
                IDLE: if (bus.cmd_valid) begin
                    op_q       <= bus.cmd_op;
                    err_q      <= ~legal;
                    inst_addr  <= bus.cmd_addr;
                    data_addr  <= bus.cmd_addr;
                    rf_addr    <= bus.cmd_addr[4:0];
                    inst_in    <= bus.cmd_data;
                    data_in    <= bus.cmd_data;
                    inst_we    <= legal & (bus.cmd_op == OP_WINST);
                    data_we    <= legal & (bus.cmd_op == OP_WDATA);
                    rf_dcp_rd  <= legal & (bus.cmd_op == OP_RRF);
                    step_pulse <= legal & (bus.cmd_op == OP_STEP);
                    state      <= ACCESS;
                end
                ACCESS: begin
                    state         <= RESP;
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_err   <= err_q;
                    rsp_q         <= 32'd0;
                    if (!err_q) begin
                        case (op_q)
                            OP_RINST:        rsp_q <= inst_out;
                            OP_RDATA:        rsp_q <= data_out;
                            OP_RRF:          rsp_q <= rf_out;
                            OP_RUN, OP_HALT: rsp_q <= pc;
                            OP_STEP:         pc_pend <= 1'b1;
`ifdef DCP_BREAKPOINT_EN
                            OP_SETBP: begin
                                bp_pc    <= inst_in;
                                bp_valid <= 1'b1;
                            end
                            OP_CLRBP:        bp_valid <= 1'b0;
`endif
                            default:         rsp_q <= 32'd0;
                        endcase
                    end
                end
                RESP: begin
                    if (pc_pend) begin
                        rsp_q   <= pc;
                        pc_pend <= 1'b0;
                    end
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // HALT outranks a coincident stop; RUN while running leaves the cause alone.
            if (state == ACCESS && !err_q && op_q == OP_HALT) begin
                running    <= 1'b0;
                halt_cause <= 2'd0;
            end else if (state == ACCESS && !err_q && op_q == OP_RUN && !running) begin
                running <= 1'b1;
`ifdef DCP_BREAKPOINT_EN
                first_run_cycle <= 1'b1;
`endif
            end else if (running && stop) begin
                running    <= 1'b0;
                halt_cause <= 2'd1;
            end else if (bp_hit) begin
                running    <= 1'b0;
                halt_cause <= 2'd2;
            end
        end
    end
endmodule

// File: tb/tb_dcp_master.sv
// Directed bench for dcp_master with a small behavioural CPU (memories, PC, stop).
module tb_dcp_master;
    localparam logic [3:0] OP_WINST = 4'd0, OP_RINST = 4'd1, OP_WDATA = 4'd2,
                           OP_RDATA = 4'd3, OP_RRF   = 4'd4, OP_RUN   = 4'd5,
                           OP_STEP  = 4'd6, OP_HALT  = 4'd7, OP_SETBP = 4'd8,
                           OP_CLRBP = 4'd9;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        inst_we, data_we, rf_dcp_rd, rf_dcp_we, cpu_ce, running, stop;
    logic [7:0]  inst_addr, data_addr;
    logic [4:0]  rf_addr;
    logic [31:0] inst_in, data_in, inst_out, data_out, rf_out, pc;
    logic [1:0]  halt_cause;

    logic [31:0] imem [256];
    logic [31:0] dmem [256];
    logic        stop_en = 1'b0;
    logic        pc_ld = 1'b0;
    logic [31:0] pc_ld_val = 32'd0;

    int n_cmp = 0, n_bad = 0;
    int n_iwe = 0, n_dwe = 0, n_rfrd = 0, n_ce = 0;
    logic [7:0] iwe_addr = 8'd0;
    logic [4:0] rfrd_addr = 5'd0;

    dcp_master_if bus();

    dcp_master dut (
        .clk(clk), .rstn(rstn), .bus(bus),
        .inst_we(inst_we), .inst_addr(inst_addr), .inst_in(inst_in), .inst_out(inst_out),
        .data_we(data_we), .data_addr(data_addr), .data_in(data_in), .data_out(data_out),
        .rf_dcp_rd(rf_dcp_rd), .rf_dcp_we(rf_dcp_we), .rf_addr(rf_addr), .rf_out(rf_out),
        .pc(pc), .stop(stop), .cpu_ce(cpu_ce), .running(running), .halt_cause(halt_cause)
    );

    always #5 clk = ~clk;

    // CPU model: combinational read-back, x1 = 5, PC advances by 4 when enabled.
    assign inst_out = imem[inst_addr];
    assign data_out = dmem[data_addr];
    assign rf_out   = (rf_addr == 5'd1) ? 32'd5 : {27'h0, rf_addr};
    assign stop     = stop_en && (pc == 32'h20);

    always @(posedge clk or negedge rstn) begin
        if (!rstn) pc <= 32'd0;
        else if (pc_ld) pc <= pc_ld_val;
        else if (cpu_ce) pc <= pc + 32'd4;
    end
    always @(posedge clk) begin
        if (inst_we) imem[inst_addr] <= inst_in;
        if (data_we) dmem[data_addr] <= data_in;
    end
    always @(negedge clk) begin
        if (inst_we)   begin n_iwe++; iwe_addr = inst_addr; end
        if (data_we)   n_dwe++;
        if (rf_dcp_rd) begin n_rfrd++; rfrd_addr = rf_addr; end
        if (cpu_ce)    n_ce++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load_pc(input logic [31:0] v);
        @(negedge clk); pc_ld = 1'b1; pc_ld_val = v;
        @(negedge clk); pc_ld = 1'b0;
    endtask

    task automatic do_cmd(input string tag, input logic [3:0] op, input logic [7:0] a,
                          input logic [31:0] d, output logic [31:0] rd, output logic er);
        int n;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_addr = a; bus.cmd_data = d;
        n = 0;
        while (!bus.cmd_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        n = 0;
        while (!bus.rsp_valid && n < 50) begin @(negedge clk); n++; end
        chk({tag, "_latency"}, n, 1);
        rd = bus.rsp_data;
        er = bus.rsp_err;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int b, n;
        bus.cmd_valid = 1'b0; bus.cmd_op = 4'd0; bus.cmd_addr = 8'd0;
        bus.cmd_data = 32'd0; bus.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_cpu_ce", cpu_ce, 0);
        chk("rst_running", running, 0);
        chk("rst_halt_cause", halt_cause, 0);
        rstn = 1'b1;
        @(negedge clk);

        b = n_iwe;
        do_cmd("winst", OP_WINST, 8'h05, 32'h00500093, rd, er);
        chk("winst_err", er, 0);
        chk("winst_data", rd, 0);
        chk("winst_we_cycles", n_iwe - b, 1);
        chk("winst_we_addr", iwe_addr, 8'h05);
        do_cmd("rinst", OP_RINST, 8'h05, 32'h0, rd, er);
        chk("rinst_data", rd, 32'h00500093);
        chk("rinst_err", er, 0);

        b = n_dwe;
        do_cmd("wdata", OP_WDATA, 8'h10, 32'hDEADBEEF, rd, er);
        chk("wdata_we_cycles", n_dwe - b, 1);
        do_cmd("rdata", OP_RDATA, 8'h10, 32'h0, rd, er);
        chk("rdata_data", rd, 32'hDEADBEEF);

        b = n_rfrd;
        do_cmd("rrf", OP_RRF, 8'h01, 32'h0, rd, er);
        chk("rrf_data", rd, 32'd5);
        chk("rrf_rd_cycles", n_rfrd - b, 1);
        chk("rrf_addr", rfrd_addr, 5'd1);

        b = n_ce;
        do_cmd("step1", OP_STEP, 8'h0, 32'h0, rd, er); chk("step1_pc", rd, 32'h4);
        do_cmd("step2", OP_STEP, 8'h0, 32'h0, rd, er); chk("step2_pc", rd, 32'h8);
        do_cmd("step3", OP_STEP, 8'h0, 32'h0, rd, er); chk("step3_pc", rd, 32'hC);
        chk("step_ce_cycles", n_ce - b, 3);

        do_cmd("illegal", 4'd12, 8'h0, 32'h0, rd, er);
        chk("illegal_err", er, 1);
        chk("illegal_data", rd, 0);

        // Run, reject a write, then halt.
        do_cmd("run", OP_RUN, 8'h0, 32'h0, rd, er);
        chk("run_err", er, 0);
        chk("run_running", running, 1);
        b = n_dwe;
        do_cmd("wdata_run", OP_WDATA, 8'h20, 32'h12345678, rd, er);
        chk("wdata_run_err", er, 1);
        chk("wdata_run_we", n_dwe - b, 0);
        do_cmd("halt", OP_HALT, 8'h0, 32'h0, rd, er);
        chk("halt_running", running, 0);
        chk("halt_cause0", halt_cause, 0);

        // CPU raises stop at pc 0x20.
        load_pc(32'h0);
        stop_en = 1'b1;
        do_cmd("run_stop", OP_RUN, 8'h0, 32'h0, rd, er);
        chk("run_stop_pc_ret", rd, 32'h0);
        n = 0;
        while (running && n < 100) begin @(negedge clk); n++; end
        chk("stop_running", running, 0);
        chk("stop_cause", halt_cause, 1);
        chk("stop_pc", pc, 32'h20);
        chk("stop_ce", cpu_ce, 0);
        repeat (2) @(negedge clk);
        chk("stop_pc_held", pc, 32'h20);
        stop_en = 1'b0;

        // Response back-pressure.
        @(negedge clk);
        bus.rsp_ready = 1'b0; bus.cmd_valid = 1'b1; bus.cmd_op = OP_RRF; bus.cmd_addr = 8'h01;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("bp_rsp_valid", bus.rsp_valid, 1);
        chk("bp_cmd_ready", bus.cmd_ready, 0);
        chk("bp_rsp_data", bus.rsp_data, 32'd5);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", bus.rsp_valid, 0);
        chk("bp_release_ready", bus.cmd_ready, 1);

`ifdef DCP_BREAKPOINT_EN
        load_pc(32'h0);
        do_cmd("setbp", OP_SETBP, 8'h0, 32'h10, rd, er);
        chk("setbp_err", er, 0);
        do_cmd("run_bp", OP_RUN, 8'h0, 32'h0, rd, er);
        n = 0;
        while (running && n < 100) begin @(negedge clk); n++; end
        chk("bphit_pc", pc, 32'h10);
        chk("bphit_cause", halt_cause, 2);
        do_cmd("run_resume", OP_RUN, 8'h0, 32'h0, rd, er);
        repeat (2) @(negedge clk);
        chk("resume_running", running, 1);
        chk("resume_past", (pc > 32'h10), 1);
        do_cmd("halt_bp", OP_HALT, 8'h0, 32'h0, rd, er);
        do_cmd("clrbp", OP_CLRBP, 8'h0, 32'h0, rd, er);
        chk("clrbp_err", er, 0);
`else
        do_cmd("setbp", OP_SETBP, 8'h0, 32'h10, rd, er);
        chk("setbp_err", er, 1);
        do_cmd("clrbp", OP_CLRBP, 8'h0, 32'h0, rd, er);
        chk("clrbp_err", er, 1);
`endif

        // Reset while running, then reset during a write's ACCESS cycle.
        do_cmd("run_rst", OP_RUN, 8'h0, 32'h0, rd, er);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("rst_run_running", running, 0);
        chk("rst_run_ce", cpu_ce, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = OP_WINST; bus.cmd_addr = 8'h07; bus.cmd_data = 32'h1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("mid_access_we", inst_we, 1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_we", inst_we, 0);
        chk("mid_rst_valid", bus.rsp_valid, 0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_rst_no_rsp", bus.rsp_valid, 0);
        chk("mid_rst_ready", bus.cmd_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
